// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter.
// Provides the return-owner encoding and the default widths and limits
// used by the arbiter top, its grant-select sub-module and its bus interface.
package mem_arb_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int MAX_DSTREAK_DEF = 4;
  localparam int CNT_W_DEF       = 16;

  // Which port the RAM read data returning this cycle belongs to.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the processor (fetch + data ports), the arbiter and
// the single-port RAM.
//   slave  : arbiter view (takes requests and RAM read data, drives grants,
//            returns and RAM address/write controls)
//   master : processor/RAM side view (the opposite directions)
// Fetch : iReq_i, iAddr_i, iFlush_i -> iGnt_o, iRValid_o, iRData_o
// Data  : dReq_i, dWe_i, dLock_i, dAddr_i, dWData_i, dWMask_i
//         -> dGnt_o, dRValid_o, dRData_o
// RAM   : memAddr_o, memWData_o, memWMask_o, memRData_i
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic                  iReq_i;
  logic [ADDR_W-1:0]     iAddr_i;
  logic                  iFlush_i;
  logic                  iGnt_o;
  logic                  iRValid_o;
  logic [DATA_W-1:0]     iRData_o;

  logic                  dReq_i;
  logic                  dWe_i;
  logic                  dLock_i;
  logic [ADDR_W-1:0]     dAddr_i;
  logic [DATA_W-1:0]     dWData_i;
  logic [DATA_W/8-1:0]   dWMask_i;
  logic                  dGnt_o;
  logic                  dRValid_o;
  logic [DATA_W-1:0]     dRData_o;

  logic [ADDR_W-1:0]     memAddr_o;
  logic [DATA_W-1:0]     memWData_o;
  logic [DATA_W/8-1:0]   memWMask_o;
  logic [DATA_W-1:0]     memRData_i;

  modport slave (
    input  iReq_i, iAddr_i, iFlush_i,
    input  dReq_i, dWe_i, dLock_i, dAddr_i, dWData_i, dWMask_i,
    input  memRData_i,
    output iGnt_o, iRValid_o, iRData_o,
    output dGnt_o, dRValid_o, dRData_o,
    output memAddr_o, memWData_o, memWMask_o
  );

  modport master (
    output iReq_i, iAddr_i, iFlush_i,
    output dReq_i, dWe_i, dLock_i, dAddr_i, dWData_i, dWMask_i,
    output memRData_i,
    input  iGnt_o, iRValid_o, iRData_o,
    input  dGnt_o, dRValid_o, dRData_o,
    input  memAddr_o, memWData_o, memWMask_o
  );

endinterface

// File: rtl/mem_port_arbiter_select.sv
// Combinational grant selection between the fetch and data ports.
// Ports:
//   ireq, dreq   : request lines of the two ports
//   locked       : data port currently holds an atomic lock
//   streak       : consecutive contested data grants so far
//   ignt, dgnt   : one-hot (or zero) grant for this cycle
//   dgnt_forced  : data grant given only because of the lock; such grants
//                  must not count toward the starvation streak
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEF,
  parameter int STREAK_W    = $clog2(MAX_DSTREAK + 1)
) (
  input  logic                ireq,
  input  logic                dreq,
  input  logic                locked,
  input  logic [STREAK_W-1:0] streak,
  output logic                ignt,
  output logic                dgnt,
  output logic                dgnt_forced
);

  always_comb begin
    ignt        = 1'b0;
    dgnt        = 1'b0;
    dgnt_forced = 1'b0;
    if (locked) begin
      // The lock owner keeps the RAM; an idle locked cycle grants nobody so
      // the read-modify-write sequence cannot be split by a fetch.
      if (dreq) begin
        dgnt        = 1'b1;
        dgnt_forced = 1'b1;
      end
    end else if (dreq && !ireq) begin
      dgnt = 1'b1;
    end else if (ireq && !dreq) begin
      ignt = 1'b1;
    end else if (ireq && dreq) begin
      if (streak == STREAK_W'(MAX_DSTREAK)) begin
        ignt = 1'b1;
      end else begin
        dgnt = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM (1-cycle read latency, byte-masked
// writes) between the instruction-fetch and data ports of the processor.
// Data has priority; a streak counter forces a fetch grant after
// MAX_DSTREAK contested data grants; a lock keeps AMO sequences atomic;
// a flush drops a stale fetch return.
// Ports:
//   clk_i            clock
//   reset_i          synchronous active-low reset
//   bus              fetch/data/RAM bundle (slave view)
//   fetchStallCnt_o  saturating count of cycles a fetch waited
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int MAX_DSTREAK = MAX_DSTREAK_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  mem_port_arbiter_if.slave    bus,
  output logic [CNT_W-1:0]     fetchStallCnt_o
);

  localparam int STREAK_W = $clog2(MAX_DSTREAK + 1);

  owner_e                rowner, rowner_nxt;
  logic [STREAK_W-1:0]   streak, streak_nxt;
  logic                  locked, locked_nxt;
  logic [CNT_W-1:0]      stall_cnt, stall_cnt_nxt;

  logic                  sel_ignt, sel_dgnt, dgnt_forced;
  logic                  ignt, dgnt;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W/8-1:0]   mem_wmask;

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [STREAK_W-1:0] sat_inc_streak(input logic [STREAK_W-1:0] v);
    return (v == STREAK_W'(MAX_DSTREAK)) ? v : v + 1'b1;
  endfunction

  mem_arb_select #(
    .MAX_DSTREAK (MAX_DSTREAK),
    .STREAK_W    (STREAK_W)
  ) u_select (
    .ireq        (bus.iReq_i),
    .dreq        (bus.dReq_i),
    .locked      (locked),
    .streak      (streak),
    .ignt        (sel_ignt),
    .dgnt        (sel_dgnt),
    .dgnt_forced (dgnt_forced)
  );

  // Request cycle: grants and RAM controls, all combinational
  assign ignt = sel_ignt & reset_i;
  assign dgnt = sel_dgnt & reset_i;

  // An ungranted cycle still presents the fetch address with no write enables,
  // which is a harmless read.
  assign mem_addr  = dgnt ? bus.dAddr_i : bus.iAddr_i;
  assign mem_wdata = dgnt ? bus.dWData_i : '0;
  assign mem_wmask = (dgnt && bus.dWe_i) ? bus.dWMask_i : '0;

  assign bus.iGnt_o     = ignt;
  assign bus.dGnt_o     = dgnt;
  assign bus.memAddr_o  = mem_addr;
  assign bus.memWData_o = mem_wdata;
  assign bus.memWMask_o = mem_wmask;

  always_comb begin
    rowner_nxt    = OWN_NONE;
    streak_nxt    = streak;
    locked_nxt    = locked;
    stall_cnt_nxt = stall_cnt;

    if (ignt) begin
      rowner_nxt = OWN_FETCH;
    end else if (dgnt && !bus.dWe_i) begin
      rowner_nxt = OWN_DATA;
    end

    if (!bus.iReq_i || ignt) begin
      streak_nxt = '0;
    end else if (dgnt && !dgnt_forced) begin
      streak_nxt = sat_inc_streak(streak);
    end

    if (dgnt && bus.dLock_i) begin
      locked_nxt = 1'b1;
    end else if (!bus.dLock_i) begin
      locked_nxt = 1'b0;
    end

    if (bus.iReq_i && !ignt) begin
      stall_cnt_nxt = sat_inc_cnt(stall_cnt);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rowner    <= OWN_NONE;
      streak    <= '0;
      locked    <= 1'b0;
      stall_cnt <= '0;
    end else begin
      rowner    <= rowner_nxt;
      streak    <= streak_nxt;
      locked    <= locked_nxt;
      stall_cnt <= stall_cnt_nxt;
    end
  end

  // Return cycle: RAM data goes straight to whichever port owns it
  assign bus.iRValid_o = reset_i && (rowner == OWN_FETCH) && !bus.iFlush_i;
  assign bus.dRValid_o = reset_i && (rowner == OWN_DATA);
  assign bus.iRData_o  = bus.memRData_i;
  assign bus.dRData_o  = bus.memRData_i;

  assign fetchStallCnt_o = stall_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .MAX_DSTREAK (4),
    .CNT_W       (4)
  ) dut (
    .clk_i           (clk),
    .reset_i         (rst_n),
    .bus             (bus),
    .fetchStallCnt_o (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: word i preloaded with 0xA000_0000 + i, 1-cycle read latency
  logic [31:0] ram [256];
  logic [31:0] ram_q;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] <= 32'hA000_0000 + 32'(i);
  end

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bus.memWMask_o[b]) ram[bus.memAddr_o[9:2]][8*b +: 8] <= bus.memWData_o[8*b +: 8];
    end
    ram_q <= ram[bus.memAddr_o[9:2]];
  end

  assign bus.memRData_i = ram_q;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        iflush;
    logic        dreq;
    logic        dwe;
    logic        dlock;
    logic [31:0] daddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        e_ignt;
    logic        e_dgnt;
    logic [31:0] e_maddr;
    logic [3:0]  e_mask;
    logic        e_irv;
    logic        e_drv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ireq, input logic [31:0] iaddr, input logic iflush,
                       input logic dreq, input logic dwe, input logic dlock,
                       input logic [31:0] daddr, input logic [31:0] wdata, input logic [3:0] wmask);
    bus.iReq_i   = ireq;
    bus.iAddr_i  = iaddr;
    bus.iFlush_i = iflush;
    bus.dReq_i   = dreq;
    bus.dWe_i    = dwe;
    bus.dLock_i  = dlock;
    bus.dAddr_i  = daddr;
    bus.dWData_i = wdata;
    bus.dWMask_i = wmask;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic chk_gnt(input string name, input logic ei, input logic ed);
    @(negedge clk);
    chk({name, " ignt"}, 64'(bus.iGnt_o), 64'(ei));
    chk({name, " dgnt"}, 64'(bus.dGnt_o), 64'(ed));
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("reset ignt", 64'(bus.iGnt_o), 64'(0));
    chk("reset stall", 64'(stall_cnt), 64'(0));
    next_cycle();
    rst_n = 1'b1;

    // Fetch stream, then masked data write and read-back
    //          ireq iaddr        fl dreq we lk daddr     wdata          mask  ig dg maddr        mk irv drv rdata
    vecs[0] = '{1, 32'h100, 0, 0, 0, 0, 32'h0,  32'h0,         4'h0, 1, 0, 32'h100, 4'h0, 0, 0, 32'h0};
    vecs[1] = '{1, 32'h104, 0, 0, 0, 0, 32'h0,  32'h0,         4'h0, 1, 0, 32'h104, 4'h0, 1, 0, 32'hA000_0040};
    vecs[2] = '{1, 32'h108, 0, 0, 0, 0, 32'h0,  32'h0,         4'h0, 1, 0, 32'h108, 4'h0, 1, 0, 32'hA000_0041};
    vecs[3] = '{0, 32'h0,   0, 0, 0, 0, 32'h0,  32'h0,         4'h0, 0, 0, 32'h0,   4'h0, 1, 0, 32'hA000_0042};
    vecs[4] = '{0, 32'h0,   0, 1, 1, 0, 32'h40, 32'hDEADBEEF,  4'h3, 0, 1, 32'h40,  4'h3, 0, 0, 32'h0};
    vecs[5] = '{0, 32'h0,   0, 1, 0, 0, 32'h40, 32'h0,         4'hF, 0, 1, 32'h40,  4'h0, 0, 0, 32'h0};
    vecs[6] = '{0, 32'h10C, 0, 0, 0, 0, 32'h0,  32'h0,         4'h0, 0, 0, 32'h10C, 4'h0, 0, 1, 32'hA000_BEEF};
    vecs[7] = '{0, 32'h0,   0, 0, 0, 0, 32'h0,  32'h0,         4'h0, 0, 0, 32'h0,   4'h0, 0, 0, 32'h0};

    for (int k = 0; k < 8; k++) begin
      drive(vecs[k].ireq, vecs[k].iaddr, vecs[k].iflush, vecs[k].dreq, vecs[k].dwe,
            vecs[k].dlock, vecs[k].daddr, vecs[k].wdata, vecs[k].wmask);
      @(negedge clk);
      chk($sformatf("v%0d ignt", k),  64'(bus.iGnt_o),     64'(vecs[k].e_ignt));
      chk($sformatf("v%0d dgnt", k),  64'(bus.dGnt_o),     64'(vecs[k].e_dgnt));
      chk($sformatf("v%0d maddr", k), 64'(bus.memAddr_o),  64'(vecs[k].e_maddr));
      chk($sformatf("v%0d mask", k),  64'(bus.memWMask_o), 64'(vecs[k].e_mask));
      chk($sformatf("v%0d irv", k),   64'(bus.iRValid_o),  64'(vecs[k].e_irv));
      chk($sformatf("v%0d drv", k),   64'(bus.dRValid_o),  64'(vecs[k].e_drv));
      if (vecs[k].e_irv) chk($sformatf("v%0d irdata", k), 64'(bus.iRData_o), 64'(vecs[k].e_rdata));
      if (vecs[k].e_drv) chk($sformatf("v%0d drdata", k), 64'(bus.dRData_o), 64'(vecs[k].e_rdata));
      next_cycle();
    end

    // Contention: four data grants, then one forced fetch, repeating
    do_reset();
    drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 4'h0);
    for (int c = 0; c < 10; c++) begin
      chk_gnt($sformatf("streak c%0d", c), (c % 5) == 4, (c % 5) != 4);
      next_cycle();
    end
    idle();
    @(negedge clk);
    chk("streak stall cnt", 64'(stall_cnt), 64'(8));
    next_cycle();

    // Lock: read, idle locked, write with lock released, then fetch
    do_reset();
    drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, 4'h0);
    chk_gnt("lock c0", 1'b0, 1'b1);
    next_cycle();
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    chk_gnt("lock c1", 1'b0, 1'b0);
    chk("lock c1 drv", 64'(bus.dRValid_o), 64'(1));
    chk("lock c1 drdata", 64'(bus.dRData_o), 64'(32'hA000_BEEF));
    next_cycle();
    drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 1'b0, 32'h48, 32'h1234_5678, 4'hF);
    chk_gnt("lock c2", 1'b0, 1'b1);
    chk("lock c2 mask", 64'(bus.memWMask_o), 64'(4'hF));
    next_cycle();
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk_gnt("lock c3", 1'b1, 1'b0);
    chk("lock c3 drv", 64'(bus.dRValid_o), 64'(0));
    next_cycle();

    // Long locked idle: fetch blocked, stall counter saturates at 4'hF
    do_reset();
    drive(1'b1, 32'h300, 1'b0, 1'b1, 1'b0, 1'b1, 32'h48, 32'h0, 4'h0);
    next_cycle();
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
    for (int c = 0; c < 20; c++) begin
      if (c == 0 || c == 19) chk_gnt($sformatf("lockhold c%0d", c), 1'b0, 1'b0);
      next_cycle();
    end
    @(negedge clk);
    chk("stall sat", 64'(stall_cnt), 64'(15));
    next_cycle();
    drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk_gnt("unlock fall", 1'b0, 1'b0);
    next_cycle();
    chk_gnt("unlock after", 1'b1, 1'b0);
    next_cycle();

    // Flush drops only the return in its own cycle
    do_reset();
    drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk_gnt("flush c0", 1'b1, 1'b0);
    next_cycle();
    drive(1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk_gnt("flush c1", 1'b1, 1'b0);
    chk("flush c1 irv", 64'(bus.iRValid_o), 64'(0));
    next_cycle();
    idle();
    @(negedge clk);
    chk("flush c2 irv", 64'(bus.iRValid_o), 64'(1));
    chk("flush c2 irdata", 64'(bus.iRData_o), 64'(32'hA000_0041));
    next_cycle();

    // Reset with a data read in flight
    do_reset();
    drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
    chk_gnt("rst c0", 1'b0, 1'b1);
    next_cycle();
    rst_n = 1'b0;
    drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'hFFFF_FFFF, 4'hF);
    chk_gnt("rst c1", 1'b0, 1'b0);
    chk("rst c1 drv", 64'(bus.dRValid_o), 64'(0));
    chk("rst c1 mask", 64'(bus.memWMask_o), 64'(0));
    next_cycle();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    chk("rst c2 drv", 64'(bus.dRValid_o), 64'(0));
    chk("rst c2 stall", 64'(stall_cnt), 64'(0));
    next_cycle();
    drive(1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 4'h0);
    for (int c = 0; c < 5; c++) begin
      chk_gnt($sformatf("rst streak c%0d", c), c == 4, c != 4);
      next_cycle();
    end
    idle();
    @(negedge clk);
    chk("ram untouched", 64'(ram[8'h10]), 64'(32'hA000_BEEF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
